beta_fetch_unit: RTL and testbench



---
 rtl/beta_pkg.sv | 34 +++
 rtl/beta_irq_sync.sv | 23 ++
 rtl/beta_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_beta_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// Shared definitions for the Beta fetch unit and control decoder: pcsel
// encoding, vector addresses, fetch FSM states and instruction field slices.
package beta_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PCSEL_W = 3;

    localparam logic [PCSEL_W-1:0] PCSEL_PLUS4 = 3'd0;
    localparam logic [PCSEL_W-1:0] PCSEL_BR    = 3'd1;
    localparam logic [PCSEL_W-1:0] PCSEL_JMP   = 3'd2;
    localparam logic [PCSEL_W-1:0] PCSEL_ILLOP = 3'd3;
    localparam logic [PCSEL_W-1:0] PCSEL_XADR  = 3'd4;

    localparam logic [XLEN-1:0] RESET_VEC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] ILLOP_VEC_DEFAULT = 32'h8000_0004;
    localparam logic [XLEN-1:0] XADR_VEC_DEFAULT  = 32'h8000_0008;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned LIT_MSB    = 15;
    localparam int unsigned LIT_LSB    = 0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

    // Sign-extended word offset of a 16-bit branch literal, in the 31-bit PC space
    function automatic logic [XLEN-2:0] br_offset(input logic [15:0] lit);
        return {{(XLEN - 19){lit[15]}}, lit, 2'b00};
    endfunction

endpackage

// File: rtl/beta_irq_sync.sv
// Multi-flop synchroniser bringing the asynchronous interrupt line into clk.
module beta_irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/beta_fetch_unit.sv
// Beta fetch unit: owns the PC, fetches from imem, hands instr/irq to decode.
// Optional fetch timeout enabled by defining BETA_FETCH_TIMEOUT_EN.
module beta_fetch_unit
    import beta_pkg::*;
#(
    parameter logic [31:0] RESET_VEC      = RESET_VEC_DEFAULT,
    parameter logic [31:0] ILLOP_VEC      = ILLOP_VEC_DEFAULT,
    parameter logic [31:0] XADR_VEC       = XADR_VEC_DEFAULT,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic [2:0]  pcsel,
    input  logic [31:0] jt,
    input  logic        step,
    input  logic        irq_async,
    output logic        irq,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        supervisor
);

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("beta_fetch_unit: SYNC_STAGES and TIMEOUT_CYCLES must both be >= 2");
    end

    fetch_state_t state, next_state;
    logic [31:0]  next_pc, pc_d, instr_d;
    logic [30:0]  pc_low_plus4;
    logic         req_d, valid_d, capture, timeout, sync_out;
    logic [1:0]   unused_jt_low;

    assign unused_jt_low = jt[1:0];
    assign pc_low_plus4  = pc[30:0] + 31'd4;
    assign pc_plus4      = {pc[31], pc_low_plus4};
    assign supervisor    = pc[31];
    assign imem_addr     = {1'b0, pc[30:2], 2'b00};
    assign capture       = (state == FETCH) && imem_ack;

    beta_irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq_async),
        .q     (sync_out)
    );

    // Combinational so decode sees the gated request alongside instr_valid
    assign irq = sync_out & ~pc[31] & (state == EXEC);

`ifdef BETA_FETCH_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [TO_W-1:0] to_cnt;

    assign timeout = (state == FETCH) && !imem_ack && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if ((state == FETCH) && !imem_ack && !timeout) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next PC; bit 31 only moves on JMP (downward only) or the vectors
    always_comb begin
        next_pc = ILLOP_VEC;
        case (pcsel)
            PCSEL_PLUS4: next_pc = pc_plus4;
            PCSEL_BR:    next_pc = {pc[31], pc_low_plus4 + br_offset(instr[15:0])};
            PCSEL_JMP:   next_pc = {pc[31] & jt[31], jt[30:2], 2'b00};
            PCSEL_ILLOP: next_pc = ILLOP_VEC;
            PCSEL_XADR:  next_pc = XADR_VEC;
            default:     next_pc = ILLOP_VEC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // A timed-out fetch passes through BOOT so the request drops for a cycle
    always_comb begin
        next_state = state;
        case (state)
            BOOT:  next_state = FETCH;
            FETCH: begin
                if (capture) begin
                    next_state = EXEC;
                end else if (timeout) begin
                    next_state = BOOT;
                end
            end
            EXEC: begin
                if (step) begin
                    next_state = FETCH;
                end
            end
            default: next_state = BOOT;
        endcase
    end

    always_comb begin
        pc_d    = pc;
        instr_d = instr;
        req_d   = (next_state == FETCH);
        valid_d = (next_state == EXEC);
        if (capture) begin
            instr_d = imem_rdata;
        end
        if (timeout) begin
            pc_d    = ILLOP_VEC;
            instr_d = '0;
        end
        if ((state == EXEC) && step) begin
            pc_d = next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_VEC;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            pc          <= pc_d;
            instr       <= instr_d;
            imem_req    <= req_d;
            instr_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_beta_fetch_unit.sv
// Directed scoreboard bench for beta_fetch_unit; the timeout section runs
// only when BETA_FETCH_TIMEOUT_EN is defined.
module tb_beta_fetch_unit;
    import beta_pkg::*;

    logic        clk, rst_n, imem_req, imem_ack, instr_valid, step, irq_async, irq, supervisor;
    logic [31:0] imem_addr, imem_rdata, instr, jt, pc, pc_plus4;
    logic [2:0]  pcsel;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];

`ifdef BETA_FETCH_TIMEOUT_EN
    beta_fetch_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
    beta_fetch_unit dut (
`endif
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pcsel       (pcsel),
        .jt          (jt),
        .step        (step),
        .irq_async   (irq_async),
        .irq         (irq),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .supervisor  (supervisor)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, then score its address
    task automatic wait_fetch(input string tag);
        int n = 0;
        logic [31:0] exp;
        @(negedge clk);
        while (imem_req !== 1'b1 && n < 32) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        exp = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_addr"}, imem_addr, exp);
    endtask

    task automatic ack_fetch(input string tag, input logic [31:0] rdata, input int delay);
        logic [31:0] exp;
        repeat (delay) @(negedge clk);
        check({tag, "_prevalid"}, 32'(instr_valid), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        exp_instr_q.push_back(rdata);
        @(posedge clk);
        #1 imem_ack = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        exp = (exp_instr_q.size() != 0) ? exp_instr_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_instr"}, instr, exp);
    endtask

    task automatic do_step(input string tag, input logic [2:0] sel, input logic [31:0] target,
                           input logic [31:0] exp);
        logic [31:0] e;
        pcsel = sel;
        jt    = target;
        step  = 1'b1;
        exp_pc_q.push_back(exp);
        exp_addr_q.push_back({1'b0, exp[30:2], 2'b00});
        @(posedge clk);
        #1 step = 1'b0;
        e = (exp_pc_q.size() != 0) ? exp_pc_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_pc"}, pc, e);
        check({tag, "_sup"}, 32'(supervisor), 32'(exp[31]));
    endtask

    task automatic insn(input string tag, input logic [31:0] rdata, input logic [2:0] sel,
                        input logic [31:0] target, input logic [31:0] exp);
        wait_fetch(tag);
        ack_fetch(tag, rdata, 0);
        do_step(tag, sel, target, exp);
    endtask

    initial begin
        rst_n = 1'b1; imem_ack = 1'b0; imem_rdata = '0; pcsel = '0;
        jt = '0; step = 1'b0; irq_async = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_sup", 32'(supervisor), 32'd1);
        check("rst_pc4", pc_plus4, 32'h8000_0004);

        // First fetch, ack on 2nd FETCH cycle
        exp_addr_q.push_back(32'h0000_0000);
        rst_n = 1'b1;
        wait_fetch("t1");
        ack_fetch("t1", 32'h8000_0000, 1);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("t1_exec_ack_instr", instr, 32'h8000_0000);
        check("t1_exec_ack_valid", 32'(instr_valid), 32'd1);
        do_step("t1", PCSEL_PLUS4, 32'h0, 32'h8000_0004);
        check("t1_pc4", pc_plus4, 32'h8000_0008);

        // Step while fetching is ignored
        wait_fetch("t1b");
        pcsel = PCSEL_JMP; jt = 32'h0; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("t1b_step_ign_pc", pc, 32'h8000_0004);
        check("t1b_step_ign_req", 32'(imem_req), 32'd1);
        ack_fetch("t1b", 32'h0, 0);
        do_step("t1b", PCSEL_JMP, 32'h0000_0100, 32'h0000_0100);

        // Branches
        insn("t2_back", 32'h0000_FFFE, PCSEL_BR, 32'h0, 32'h0000_00FC);
        insn("t2_fwd", 32'h0000_0010, PCSEL_BR, 32'h0, 32'h0000_0140);

        // JMP privilege
        insn("t3a", 32'h0, PCSEL_JMP, 32'h0000_0040, 32'h0000_0040);
        insn("t3b", 32'h0, PCSEL_JMP, 32'h8000_1237, 32'h0000_1234);
        insn("t3c", 32'h0, PCSEL_ILLOP, 32'h0, 32'h8000_0004);
        insn("t3d", 32'h0, PCSEL_JMP, 32'h8000_0040, 32'h8000_0040);
        insn("t3e", 32'h0, PCSEL_JMP, 32'h8000_1237, 32'h8000_1234);

        // Interrupt masked in supervisor mode, taken after JMP to user
        irq_async = 1'b1;
        wait_fetch("t4a");
        ack_fetch("t4a", 32'h0, 0);
        check("t4a_irq_masked", 32'(irq), 32'd0);
        do_step("t4a", PCSEL_JMP, 32'h0000_0200, 32'h0000_0200);
        wait_fetch("t4b");
        check("t4b_irq_fetch", 32'(irq), 32'd0);
        ack_fetch("t4b", 32'h0, 0);
        check("t4b_irq_user", 32'(irq), 32'd1);
        do_step("t4b", PCSEL_XADR, 32'h0, 32'h8000_0008);

        // Synchroniser latency and a request withdrawn before step
        irq_async = 1'b0;
        insn("t4c", 32'h0, PCSEL_JMP, 32'h0000_0300, 32'h0000_0300);
        wait_fetch("t4d");
        ack_fetch("t4d", 32'h0, 0);
        check("t4d_irq_idle", 32'(irq), 32'd0);
        irq_async = 1'b1;
        @(negedge clk);
        check("t4d_irq_1cyc", 32'(irq), 32'd0);
        @(negedge clk);
        check("t4d_irq_2cyc", 32'(irq), 32'd1);
        irq_async = 1'b0;
        repeat (2) @(negedge clk);
        check("t4d_irq_drop", 32'(irq), 32'd0);
        do_step("t4d", PCSEL_PLUS4, 32'h0, 32'h0000_0304);

        // Undefined pcsel and wrap-around
        insn("t5a", 32'h0, 3'd6, 32'h0, 32'h8000_0004);
        insn("t5b", 32'h0, 3'd7, 32'h0, 32'h8000_0004);
        insn("t5c", 32'h0, PCSEL_JMP, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        insn("t5d", 32'h0, PCSEL_PLUS4, 32'h0, 32'h8000_0000);
        insn("t5e", 32'h0, PCSEL_JMP, 32'h7FFF_FFFC, 32'h7FFF_FFFC);
        insn("t5f", 32'h0, PCSEL_PLUS4, 32'h0, 32'h0000_0000);

`ifdef BETA_FETCH_TIMEOUT_EN
        // No ack: timeout on the 4th FETCH cycle, then a fresh request
        wait_fetch("t6a");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("t6a_to_pc", pc, 32'h8000_0004);
        check("t6a_to_req", 32'(imem_req), 32'd0);
        check("t6a_to_instr", instr, 32'h0);
        exp_addr_q.push_back(32'h0000_0004);
        wait_fetch("t6b");
        ack_fetch("t6b", 32'h1234_5678, 3);
        check("t6b_pc", pc, 32'h8000_0004);
        do_step("t6b", PCSEL_PLUS4, 32'h0, 32'h8000_0008);
`endif

        // Reset mid-fetch drops the request at once; late ack ignored in BOOT
        wait_fetch("t7");
        #2 rst_n = 1'b0;
        #1;
        check("t7_req_async", 32'(imem_req), 32'd0);
        check("t7_pc", pc, 32'h8000_0000);
        imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 imem_ack = 1'b0;
        check("t7_boot_ack_valid", 32'(instr_valid), 32'd0);
        check("t7_boot_ack_instr", instr, 32'h0);
        check("t7_refetch_req", 32'(imem_req), 32'd1);
        check("t7_refetch_addr", imem_addr, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
